// File: rtl/fp_accumulator_if.sv
// rtl/fp_accumulator_if.sv - stream and status bundle between fp_accumulator and its producer/consumer
interface fp_accumulator_if;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        overflow;
    logic        busy;

    modport master (
        output start, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, overflow, busy
    );

    modport slave (
        input  start, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, overflow, busy
    );
endinterface

// File: rtl/fp_accumulator.sv
// rtl/fp_accumulator.sv - binary32 N-term accumulator around a combinational adder; FP_ACC_RELU_EN clamps negative results to +0
module fp_accumulator_add (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum,
    output logic        overflow
);
    logic        a_inf, a_nan, b_inf, b_nan, swap, rnd;
    logic [31:0] x, y;
    logic [7:0]  ex, ey, diff;
    logic [23:0] mx, my;
    logic [26:0] mx_ext, my_ext, my_sh, norm;
    logic [27:0] raw;
    logic [9:0]  exp_w, lim, sh;
    logic [4:0]  lz;
    logic [30:0] packed_r;

    always_comb begin
        a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);

        // x is always the operand of larger magnitude, so it owns the sign
        swap = b[30:0] > a[30:0];
        x    = swap ? b : a;
        y    = swap ? a : b;
        ex   = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
        ey   = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
        mx   = {x[30:23] != 8'd0, x[22:0]};
        my   = {y[30:23] != 8'd0, y[22:0]};
        diff = ex - ey;

        mx_ext = {mx, 3'b000};
        my_ext = {my, 3'b000};
        if (diff >= 8'd27)
            my_sh = {26'd0, |my};
        else
            my_sh = (my_ext >> diff) | {26'd0, |(my_ext & ~({27{1'b1}} << diff))};

        if (x[31] ^ y[31])
            raw = {1'b0, mx_ext} - {1'b0, my_sh};
        else
            raw = {1'b0, mx_ext} + {1'b0, my_sh};

        lz = 5'd27;
        for (int i = 0; i < 27; i++)
            if (raw[i]) lz = 5'(26 - i);

        exp_w = {2'b00, ex};
        lim   = exp_w - 10'd1;
        sh    = 10'd0;
        norm  = raw[26:0];
        if (raw[27]) begin
            norm  = {raw[27:2], raw[1] | raw[0]};
            exp_w = exp_w + 10'd1;
        end else begin
            // never normalise below the minimum exponent: leaves a subnormal
            sh    = ({5'd0, lz} < lim) ? {5'd0, lz} : lim;
            norm  = raw[26:0] << sh;
            exp_w = exp_w - sh;
        end
        if (!norm[26]) exp_w = 10'd0;

        rnd      = norm[2] & (norm[1] | norm[0] | norm[3]);
        packed_r = {exp_w[7:0], norm[25:3]} + {30'd0, rnd};

        if (raw == 28'd0)
            sum = {x[31] & y[31], 31'd0};
        else if (exp_w >= 10'd255)
            sum = {x[31], 8'hFF, 23'd0};
        else
            sum = {x[31], packed_r};

        if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31])))
            sum = 32'h7FC0_0000;
        else if (a_inf)
            sum = a;
        else if (b_inf)
            sum = b;

        overflow = sum[30:23] == 8'hFF;
    end
endmodule

module fp_accumulator #(
    parameter int N  = 4,
    parameter int CW = 8
) (
    input  logic clk,
    input  logic rst,
    fp_accumulator_if.slave s
);
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t          state_q, state_d;
    logic [31:0]     acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic            overflow_q, overflow_d;

    logic [31:0]     add_sum, acc_upd, result;
    logic            add_ovf, xfer, term_zero, direct_load, term_ovf;

    fp_accumulator_add u_add (
        .a        (acc_q),
        .b        (s.in_data),
        .sum      (add_sum),
        .overflow (add_ovf)
    );

    assign s.in_ready  = state_q == ACC;
    assign s.busy      = state_q != IDLE;
    assign s.out_valid = out_valid_q;
    assign s.out_data  = out_data_q;
    assign s.overflow  = overflow_q;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overflow_d  = overflow_q;

        // zero terms and empty accumulators bypass the adder entirely
        term_zero   = s.in_data[30:0] == 31'd0;
        direct_load = (cnt_q == '0) || (acc_q[30:0] == 31'd0);
        acc_upd     = term_zero ? acc_q : (direct_load ? s.in_data : add_sum);
        term_ovf    = (!term_zero && !direct_load && add_ovf) || (s.in_data[30:23] == 8'hFF);
`ifdef FP_ACC_RELU_EN
        result      = acc_upd[31] ? 32'd0 : acc_upd;
`else
        result      = acc_upd;
`endif
        xfer        = s.in_valid && (state_q == ACC);

        case (state_q)
            IDLE: begin
                if (s.start) begin
                    acc_d      = 32'd0;
                    cnt_d      = '0;
                    overflow_d = 1'b0;
                    state_d    = ACC;
                end
            end
            ACC: begin
                if (xfer) begin
                    acc_d      = acc_upd;
                    cnt_d      = cnt_q + CW'(1);
                    overflow_d = overflow_q | term_ovf;
                    if (cnt_q == CW'(N - 1)) begin
                        state_d     = DONE;
                        out_data_d  = result;
                        out_valid_d = 1'b1;
                    end
                end
            end
            DONE: begin
                if (s.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= 32'd0;
            cnt_q       <= '0;
            out_data_q  <= 32'd0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
        end
    end
endmodule

// File: tb/tb_fp_accumulator.sv
// tb/tb_fp_accumulator.sv - randomized check of fp_accumulator (N=1..4) against an exact-arithmetic reference
module tb_fp_accumulator;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'd0;
    logic        out_ready = 1'b0;
    logic [1:0]  sel = 2'd3;

    logic [3:0]  ready_a, valid_a, ovf_a, busy_a;
    logic [31:0] data_a [4];
    logic        obs_in_ready, obs_out_valid, obs_overflow, obs_busy;
    logic [31:0] obs_out_data;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] terms_q[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        fp_accumulator_if bus ();
        fp_accumulator #(.N(g + 1), .CW(8)) u_dut (
            .clk (clk),
            .rst (rst),
            .s   (bus)
        );
        assign bus.start     = start && (sel == 2'(g));
        assign bus.in_valid  = in_valid;
        assign bus.in_data   = in_data;
        assign bus.out_ready = out_ready;
        assign ready_a[g]    = bus.in_ready;
        assign valid_a[g]    = bus.out_valid;
        assign ovf_a[g]      = bus.overflow;
        assign busy_a[g]     = bus.busy;
        assign data_a[g]     = bus.out_data;
    end

    assign obs_in_ready  = ready_a[sel];
    assign obs_out_valid = valid_a[sel];
    assign obs_overflow  = ovf_a[sel];
    assign obs_busy      = busy_a[sel];
    assign obs_out_data  = data_a[sel];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Exact value scaled by 2^149 so every finite binary32 is an integer
    function automatic logic signed [299:0] to_fix(input logic [31:0] v);
        logic signed [299:0] m;
        m = '0;
        m[23:0] = {v[30:23] != 8'd0, v[22:0]};
        if (v[30:23] != 8'd0) m = m <<< (int'(v[30:23]) - 1);
        return v[31] ? -m : m;
    endfunction

    function automatic logic [31:0] from_fix(input logic signed [299:0] v);
        logic [299:0] mag, one, rem, half, q;
        logic sgn, up;
        logic [30:0] pk;
        int p, e, sh;
        sgn = v[299];
        mag = sgn ? 300'(-v) : 300'(v);
        if (mag == '0) return 32'd0;
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        e = p - 22;
        if (e < 1) return {sgn, 8'd0, mag[22:0]};
        if (e >= 255) return {sgn, 8'hFF, 23'd0};
        sh = e - 1;
        q = mag >> sh;
        one = 1;
        up = 1'b0;
        if (sh > 0) begin
            rem  = mag & ((one << sh) - one);
            half = one << (sh - 1);
            up   = (rem > half) || ((rem == half) && q[0]);
        end
        pk = {8'(e), q[22:0]} + 31'(up);
        return {sgn, pk};
    endfunction

    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        logic ai, bi, an, bn;
        ai = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        bi = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        an = (a[30:23] == 8'hFF) && !ai;
        bn = (b[30:23] == 8'hFF) && !bi;
        if (an || bn || (ai && bi && a[31] != b[31])) return 32'h7FC0_0000;
        if (ai) return a;
        if (bi) return b;
        return from_fix(to_fix(a) + to_fix(b));
    endfunction

    task automatic model_acc(output logic [31:0] res, output logic ov);
        logic [31:0] acc;
        acc = 32'd0;
        ov  = 1'b0;
        foreach (terms_q[k]) begin
            if (terms_q[k][30:0] != 31'd0) begin
                if (k == 0 || acc[30:0] == 31'd0) acc = terms_q[k];
                else begin
                    acc = ref_add(acc, terms_q[k]);
                    if (acc[30:23] == 8'hFF) ov = 1'b1;
                end
            end
            if (terms_q[k][30:23] == 8'hFF) ov = 1'b1;
        end
`ifdef FP_ACC_RELU_EN
        res = acc[31] ? 32'd0 : acc;
`else
        res = acc;
`endif
    endtask

    task automatic run_acc(input logic [1:0] idx, input int bmin, input int bmax, input int hold);
        logic [31:0] exp_d;
        logic        exp_o;
        sel = idx;
        model_acc(exp_d, exp_o);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("ready_after_start", obs_in_ready, 1);
        foreach (terms_q[i]) begin
            repeat ($urandom_range(bmin, bmax)) @(negedge clk);
            in_valid = 1'b1;
            in_data  = terms_q[i];
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = $urandom;
            if (i < terms_q.size() - 1) check_eq("early_valid", obs_out_valid, 0);
        end
        check_eq("out_valid", obs_out_valid, 1);
        check_eq("out_data", obs_out_data, exp_d);
        check_eq("overflow", obs_overflow, 32'(exp_o));
        check_eq("ready_in_done", obs_in_ready, 0);
        check_eq("busy_in_done", obs_busy, 1);
        repeat (hold) begin
            start    = 1'b1;
            in_valid = 1'b1;
            @(negedge clk);
            check_eq("hold_valid", obs_out_valid, 1);
            check_eq("hold_data", obs_out_data, exp_d);
            check_eq("hold_ready", obs_in_ready, 0);
        end
        in_valid  = 1'b0;
        start     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        check_eq("valid_after_hs", obs_out_valid, 0);
        check_eq("busy_after_hs", obs_busy, 0);
        check_eq("data_kept_idle", obs_out_data, exp_d);
        check_eq("overflow_kept", obs_overflow, 32'(exp_o));
    endtask

    function automatic logic [31:0] rand_term();
        if ($urandom_range(0, 5) == 0) return {1'($urandom), 31'd0};
        return {1'($urandom), 8'($urandom_range(110, 144)), 23'($urandom)};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_eq("rst_out_valid", obs_out_valid, 0);
        check_eq("rst_out_data", obs_out_data, 0);
        check_eq("rst_overflow", obs_overflow, 0);
        check_eq("rst_busy", obs_busy, 0);
        rst = 1'b0;

        // abort an accumulation two terms in
        sel = 2'd3;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        in_data = 32'h7F80_0000;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort_valid", obs_out_valid, 0);
        check_eq("abort_busy", obs_busy, 0);
        check_eq("abort_overflow", obs_overflow, 0);
        check_eq("abort_ready", obs_in_ready, 0);
        repeat (2) @(negedge clk);
        check_eq("abort_no_pulse", obs_out_valid, 0);
        terms_q = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'hBF00_0000};
        run_acc(2'd3, 0, 0, 0);

        terms_q = '{32'h3F80_0000};
        run_acc(2'd0, 0, 0, 0);
        terms_q = '{32'h4000_0000, 32'hC000_0000};
        run_acc(2'd1, 0, 0, 0);
        terms_q = '{32'h3F80_0000, 32'hC040_0000};
        run_acc(2'd1, 0, 1, 0);
        terms_q = '{32'h0000_0000, 32'h3F00_0000, 32'h8000_0000};
        run_acc(2'd2, 2, 2, 0);
        terms_q = '{32'h3F80_0000, 32'h7F80_0000};
        run_acc(2'd1, 0, 0, 1);
        terms_q = '{32'h3F80_0000, 32'h3F80_0000};
        run_acc(2'd1, 0, 0, 0);
        terms_q = '{32'h4120_0000, 32'hC120_0000, 32'h3E80_0000, 32'h4049_0FDB};
        run_acc(2'd3, 0, 1, 5);

        for (int r = 0; r < 60; r++) begin
            logic [1:0] idx;
            idx = 2'($urandom_range(0, 3));
            terms_q.delete();
            for (int k = 0; k <= int'(idx); k++) begin
                if (k > 0 && $urandom_range(0, 4) == 0)
                    terms_q.push_back(terms_q[k-1] ^ 32'h8000_0000);
                else
                    terms_q.push_back(rand_term());
            end
            run_acc(idx, 0, 2, $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fp_accumulator.md
Name: fp_accumulator

Overview:
- Sequential front-end around the combinational single-precision Adder.
- Accepts a stream of N IEEE-754 binary32 terms over a valid/ready handshake and reduces them to one sum. It does this by feeding its running-sum register and each new term into one Adder instance.
- Produces the net-input sum for a Maxnet neuron update (self term plus inhibition terms), which is then consumed by the activation/update logic.

Parameters:
- N, default 4: number of terms per accumulation. Legal range 1..255.
- CW, default 8: width of the term counter. Must satisfy 2^CW > N.

Ports:
- clk, input, 1: single clock; all state updates on rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: begin a new accumulation. Honoured only in IDLE.
- in_valid, input, 1: in_data holds a valid term.
- in_ready, output, 1: block can accept a term. Equals (state==ACC), combinational.
- in_data, input, 32: term, binary32.
- out_valid, output, 1: sum available. Registered.
- out_ready, input, 1: consumer accepts the sum.
- out_data, output, 32: accumulated sum, binary32. Registered.
- overflow, output, 1: sticky. Set if any term or any partial sum had exponent 0xFF during the current accumulation.
- busy, output, 1: high in ACC or DONE.

Behaviour:
- Reset (rst=1 at clk edge), from any state:
  - state goes to IDLE; acc, cnt, out_data and overflow go to 0; out_valid goes to 0.
  - An accumulation in progress is aborted with no out_valid pulse.
- FSM states: IDLE, ACC, DONE.
- IDLE:
  - start=1 clears acc, cnt and overflow, and moves to ACC.
  - out_data keeps the previous result.
- ACC: a transfer occurs on a cycle with in_valid && in_ready. On each transfer:
  - If in_data[30:0]==0 (±0): acc is unchanged; the term is still counted. The Adder's zero-operand path is never used.
  - Else if cnt==0 or acc[30:0]==0: acc <= in_data (direct load, no add).
  - Else: acc <= Adder(acc, in_data); overflow <= overflow | Adder.overflow.
  - If in_data[30:23]==8'hFF: overflow <= 1.
  - cnt <= cnt+1.
  - If cnt==N-1 at the transfer: move to DONE. out_data <= the value being written to acc; out_valid <= 1 on the same edge.
- Bubbles: in_valid=0 cycles leave all state unchanged. There is no timeout.
- Latency: out_valid rises on the edge that accepts the Nth term, so it is visible the cycle after that term was presented. Throughput is 1 term/cycle.
- DONE:
  - out_valid=1 and out_data held stable until out_ready=1.
  - On the out_ready handshake: out_valid <= 0 and state goes to IDLE. A start in that same cycle is ignored; start is sampled only in IDLE.
- start asserted in ACC or DONE is ignored. in_data presented while in_ready=0 is not consumed.
- N==1: first transfer loads acc and goes directly to DONE.
- Sign of result comes from the Adder. Exact cancellation (x + -x) yields 0x00000000 per the Adder. A subsequent nonzero term then reloads acc directly, per the rule above.
- overflow is valid with out_valid. It holds until the next start or rst.

Optional Feature:
- Macro: FP_ACC_RELU_EN.
- Defined: when transferring the final sum to out_data, any result with bit31=1 is replaced by 0x00000000. This is the Maxnet ReLU and is applied before out_valid rises. acc itself is unclamped.
- Undefined: out_data is the raw signed sum.
- overflow behaviour is identical in both builds.

Test Plan:
- Reset mid-ACC: with N=4, accept 2 terms, assert rst for 1 cycle -> out_valid=0, busy=0, overflow=0, in_ready=0. A new start then accepts 4 fresh terms.
- N=1, term 0x3F800000 (1.0) -> out_valid one cycle after transfer, out_data=0x3F800000, overflow=0.
- N=2, terms 0x40000000 then 0xC0000000 (2.0, -2.0) -> out_data=0x00000000. In a FP_ACC_RELU_EN build, terms 0x3F800000 then 0xC0400000 must give out_data=0x00000000 whenever the raw Adder sum is negative.
- N=3, terms 0x00000000, 0x3F000000, 0x00000000 with a 2-cycle in_valid bubble between each -> out_data=0x3F000000 (zeros skipped), done only after the third transfer.
- N=2, second term 0x7F800000 (+inf) -> overflow=1 at out_valid and stays 1 until the next start. The next clean run gives overflow=0.
- Backpressure: N=4, hold out_ready=0 for 5 cycles after out_valid -> out_data stable, in_ready=0, start ignored. out_ready=1 then returns the block to IDLE. General sums are compared against a chained-Adder reference model.
